// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the IF/MEM memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_DONE
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_e;

  localparam int MEM_LAT_DEF          = 2;
  localparam int FETCH_STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner selection between fetch and data requests, with a saturating
// starvation counter that forces a fetch grant after repeated losses.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int FETCH_STARVE_MAX = FETCH_STARVE_MAX_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   decide,
  input  logic   if_req,
  input  logic   dm_req,
  output logic   win_valid,
  output owner_e win_owner
);

  localparam int CW = $clog2(FETCH_STARVE_MAX + 1);

  logic [CW-1:0] starve_q, starve_d;
  logic          starved;
  logic          if_win;

  always_comb begin
    starved   = (starve_q == CW'(FETCH_STARVE_MAX));
    if_win    = if_req && (!dm_req || starved);
    win_valid = if_req || dm_req;
    win_owner = if_win ? OWN_IF : OWN_DM;
    starve_d  = starve_q;
    // The counter only moves at arbitration points; a fetch loss bumps it.
    if (decide) begin
      if (!if_req || if_win) starve_d = '0;
      else if (!starved)     starve_d = starve_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) starve_q <= '0;
    else      starve_q <= starve_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-ported memory between instruction fetch and
// data access, one transaction at a time; every output is registered.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT          = MEM_LAT_DEF,
  parameter int FETCH_STARVE_MAX = FETCH_STARVE_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [63:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_ack,
  output logic [63:0] dm_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic        busy
);

  localparam int LW = $clog2(MEM_LAT + 1);

  state_e        state_q;
  owner_e        owner_q;
  logic          we_q, drop_q;
  logic [LW-1:0] lat_q;
  logic          mem_en_q, mem_we_q, if_gnt_q, dm_gnt_q, if_rvalid_q, dm_ack_q;
  logic [31:0]   mem_addr_q, if_rdata_q;
  logic [63:0]   mem_wdata_q, dm_rdata_q;

  logic          decide, win_valid, flush_hit;
  owner_e        win_owner;

  assign decide    = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign flush_hit = if_flush && (owner_q == OWN_IF) && (state_q != ST_IDLE);

  mem_arb_prio #(.FETCH_STARVE_MAX(FETCH_STARVE_MAX)) u_prio (
    .clk       (clk),
    .rst       (rst),
    .decide    (decide),
    .if_req    (if_req),
    .dm_req    (dm_req),
    .win_valid (win_valid),
    .win_owner (win_owner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      we_q        <= 1'b0;
      drop_q      <= 1'b0;
      lat_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_ack_q    <= 1'b0;
      if (flush_hit) drop_q <= 1'b1;
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (win_valid) begin
            state_q  <= ST_ACCESS;
            owner_q  <= win_owner;
            drop_q   <= 1'b0;
            mem_en_q <= 1'b1;
            if (win_owner == OWN_IF) begin
              we_q       <= 1'b0;
              mem_addr_q <= if_addr;
              if_gnt_q   <= 1'b1;
            end else begin
              we_q        <= dm_we;
              mem_we_q    <= dm_we;
              mem_addr_q  <= dm_addr;
              mem_wdata_q <= dm_we ? dm_wdata : '0;
              dm_gnt_q    <= 1'b1;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (we_q) begin
            state_q  <= ST_DONE;
            dm_ack_q <= 1'b1;
          end else begin
            state_q <= ST_WAIT;
            lat_q   <= LW'(MEM_LAT);
          end
        end
        ST_WAIT: begin
          if (lat_q == LW'(1)) begin
            state_q <= ST_DONE;
            // A flush seen on the capture edge itself still drops the fetch.
            if (owner_q == OWN_IF) begin
              if (!(drop_q || if_flush)) begin
                if_rdata_q  <= mem_rdata[31:0];
                if_rvalid_q <= 1'b1;
              end
            end else begin
              dm_rdata_q <= mem_rdata;
              dm_ack_q   <= 1'b1;
            end
          end else begin
            lat_q <= lat_q - LW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign if_gnt    = if_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_gnt    = dm_gnt_q;
  assign dm_ack    = dm_ack_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios for mem_arbiter; grants and completions are matched
// against a time-stamped expected-event queue by an independent monitor.
module tb_mem_arbiter;

  localparam int W = 118;
  localparam logic [5:0] F_IFG = 6'b100010;
  localparam logic [5:0] F_DMR = 6'b010010;
  localparam logic [5:0] F_DMW = 6'b010011;
  localparam logic [5:0] F_RV  = 6'b001000;
  localparam logic [5:0] F_ACK = 6'b000100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, if_flush = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0;
  logic [63:0] dm_wdata = '0, mem_rdata = '0;
  logic        if_gnt, if_rvalid, dm_gnt, dm_ack, mem_en, mem_we, busy;
  logic [31:0] if_rdata, mem_addr;
  logic [63:0] dm_rdata, mem_wdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int e, e2;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs, expv;
  logic [63:0]  mon_d;
  logic [63:0]  model_mem [logic [31:0]];
  logic         rd_v1 = 1'b0, rd_v2 = 1'b0;
  logic [31:0]  rd_a1 = '0, rd_a2 = '0;

  mem_arbiter #(.MEM_LAT(2), .FETCH_STARVE_MAX(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Clock and cycle index; cycle n is the period after the n-th rising edge.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Backing memory: data appears two cycles after the access cycle.
  always @(posedge clk) begin
    #1;
    mem_rdata = rd_v2 ? (model_mem.exists(rd_a2) ? model_mem[rd_a2] : 64'h0)
                      : 64'hBAD0_BAD0_BAD0_BAD0;
    rd_v2 = rd_v1;
    rd_a2 = rd_a1;
    rd_v1 = mem_en && !mem_we;
    rd_a1 = mem_addr;
    if (mem_en && mem_we) model_mem[mem_addr] = mem_wdata;
  end

  // Monitor: every grant/completion pulse is checked against the queue head.
  always @(negedge clk) begin
    if (rst === 1'b1 && (if_gnt || dm_gnt || if_rvalid || dm_ack)) begin
      mon_d = if_rvalid ? {32'h0, if_rdata} : (dm_ack ? dm_rdata : mem_wdata);
      obs = {16'(cyc), if_gnt, dm_gnt, if_rvalid, dm_ack, mem_en, mem_we, mem_addr, mon_d};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event got=%h required=none", obs);
      end else begin
        expv = exp_q.pop_front();
        if (obs !== expv) begin
          failures++;
          $display("FAIL event got=%h required=%h", obs, expv);
        end
      end
    end
  end

  function automatic logic [198:0] outs();
    return {if_gnt, if_rvalid, if_rdata, dm_gnt, dm_ack, dm_rdata,
            mem_en, mem_we, mem_addr, mem_wdata, busy};
  endfunction

  task automatic push(int c, logic [5:0] f, logic [31:0] a, logic [63:0] d);
    exp_q.push_back({16'(c), f, a, d});
  endtask

  task automatic check(string name, logic [198:0] act, logic [198:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, act, req);
    end
  endtask

  task automatic at(int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    model_mem[32'h40]  = 64'hFFFF_FFFF_00A0_0093;
    model_mem[32'h44]  = 64'h0000_0000_0BAD_F00D;
    model_mem[32'h48]  = 64'h7777_7777_0040_0113;
    model_mem[32'h80]  = 64'hAAAA_BBBB_1300_0513;
    model_mem[32'hC0]  = 64'h5555_5555_0000_00C1;
    model_mem[32'hC4]  = 64'h6666_6666_0000_00C5;
    model_mem[32'h100] = 64'h1111_2222_3333_4444;
    model_mem[32'h300] = 64'h0300_0000_0000_0001;
    model_mem[32'h308] = 64'h0300_0000_0000_0002;
    model_mem[32'h310] = 64'h0300_0000_0000_0003;
    model_mem[32'h318] = 64'h0300_0000_0000_0004;

    #1 rst = 1'b0;
    #2 check("reset_outputs", outs(), '0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Fetch read
    e = cyc + 1;
    if_req = 1'b1; if_addr = 32'h40;
    push(e, F_IFG, 32'h40, '0);
    push(e + 3, F_RV, '0, {32'h0, 32'h00A0_0093});
    at(e);     if_req = 1'b0;
    at(e + 4); check("busy_after_fetch", 199'(busy), '0);

    // Contention: data wins, fetch follows with no idle bubble
    at(e + 5);
    e = cyc + 1;
    if_req = 1'b1; if_addr = 32'h80;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100; dm_wdata = '0;
    push(e,     F_DMR, 32'h100, '0);
    push(e + 3, F_ACK, '0, 64'h1111_2222_3333_4444);
    push(e + 4, F_IFG, 32'h80, '0);
    push(e + 7, F_RV,  '0, {32'h0, 32'h1300_0513});
    at(e);     dm_req = 1'b0;
    at(e + 4); if_req = 1'b0;
    at(e + 8); check("busy_after_contention", 199'(busy), '0);

    // Store, then a load reading it back
    at(e + 9);
    e = cyc + 1;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 64'hDEAD_BEEF;
    push(e,     F_DMW, 32'h200, 64'hDEAD_BEEF);
    push(e + 1, F_ACK, '0, 64'h1111_2222_3333_4444);
    at(e);     dm_req = 1'b0; dm_we = 1'b0; dm_wdata = '0;
    at(e + 2); check("busy_after_store", 199'(busy), '0);
    e2 = cyc + 1;
    dm_req = 1'b1; dm_addr = 32'h200;
    push(e2,     F_DMR, 32'h200, '0);
    push(e2 + 3, F_ACK, '0, 64'h0000_0000_DEAD_BEEF);
    at(e2);     dm_req = 1'b0;
    at(e2 + 4); check("busy_after_load", 199'(busy), '0);

    // Starvation: with a bound of 2, the third decision goes to fetch
    at(e2 + 5);
    e = cyc + 1;
    if_req = 1'b1; if_addr = 32'hC0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    push(e,      F_DMR, 32'h300, '0);
    push(e + 3,  F_ACK, '0, 64'h0300_0000_0000_0001);
    push(e + 4,  F_DMR, 32'h308, '0);
    push(e + 7,  F_ACK, '0, 64'h0300_0000_0000_0002);
    push(e + 8,  F_IFG, 32'hC0, '0);
    push(e + 11, F_RV,  '0, {32'h0, 32'h0000_00C1});
    push(e + 12, F_DMR, 32'h310, '0);
    push(e + 15, F_ACK, '0, 64'h0300_0000_0000_0003);
    push(e + 16, F_DMR, 32'h318, '0);
    push(e + 19, F_ACK, '0, 64'h0300_0000_0000_0004);
    push(e + 20, F_IFG, 32'hC4, '0);
    push(e + 23, F_RV,  '0, {32'h0, 32'h0000_00C5});
    at(e);      dm_addr = 32'h308;
    at(e + 4);  dm_addr = 32'h310;
    at(e + 8);  if_addr = 32'hC4;
    at(e + 12); dm_addr = 32'h318;
    at(e + 16); dm_req = 1'b0;
    at(e + 20); if_req = 1'b0;
    at(e + 24); check("busy_after_starve", 199'(busy), '0);

    // Flush on the capture cycle drops the fetch; next request still granted
    at(e + 25);
    e = cyc + 1;
    if_req = 1'b1; if_addr = 32'h44;
    push(e, F_IFG, 32'h44, '0);
    at(e);     if_req = 1'b0;
    at(e + 2); if_flush = 1'b1;
    at(e + 3);
    if_flush = 1'b0;
    check("flush_no_rvalid", 199'(if_rvalid), '0);
    check("flush_keeps_rdata", 199'(if_rdata), 199'(32'h0000_00C5));
    if_req = 1'b1; if_addr = 32'h48;
    push(e + 4, F_IFG, 32'h48, '0);
    push(e + 7, F_RV,  '0, {32'h0, 32'h0040_0113});
    at(e + 4); if_req = 1'b0;
    at(e + 8); check("busy_after_flush", 199'(busy), '0);

    // Reset in the middle of a load
    at(e + 9);
    e = cyc + 1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    push(e, F_DMR, 32'h300, '0);
    at(e);     dm_req = 1'b0;
    at(e + 1); rst = 1'b0;
    #1 check("reset_mid_read", outs(), '0);
    at(e + 2); rst = 1'b1;
    at(e + 4);
    e2 = cyc + 1;
    dm_req = 1'b1; dm_addr = 32'h310;
    push(e2,     F_DMR, 32'h310, '0);
    push(e2 + 3, F_ACK, '0, 64'h0300_0000_0000_0003);
    at(e2);     dm_req = 1'b0;
    at(e2 + 4); check("busy_after_reset_load", 199'(busy), '0);

    repeat (6) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events got=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
